linear_weight_tile_scheduler: RTL and testbench
===============================================

// Module: linear_weight_tile_scheduler
// PURPOSE
//  Sequences weight tiles for a tiled fixed_linear layer when parallelism < tensor size.
//  Generates ROM addresses in the order fixed_linear consumes them and streams tiles on valid/ready.
//  Tags each tile with accumulate-flush and end-of-pass markers.
//  Sits between the per-layer weight ROM and the linear core's weight port, replacing the free-running weight source.
// PARAMETERS
//  WEIGHT_PRECISION_0            8    bits per weight element
//  WEIGHT_TENSOR_SIZE_DIM_0      784  input features; must be a multiple of WEIGHT_PARALLELISM_DIM_0
//  WEIGHT_PARALLELISM_DIM_0      28   input features per tile
//  WEIGHT_TENSOR_SIZE_DIM_1      10   output features; must be a multiple of WEIGHT_PARALLELISM_DIM_1
//  WEIGHT_PARALLELISM_DIM_1      2    output features per tile
//  DATA_IN_0_TENSOR_SIZE_DIM_1   1    input rows per pass; must be a multiple of DATA_IN_0_PARALLELISM_DIM_1
//  DATA_IN_0_PARALLELISM_DIM_1   1    rows per beat
//  Derived constants:
//   IN_DEPTH  = TS_DIM_0 / P_DIM_0
//   OUT_DEPTH = TS_DIM_1 / P_DIM_1
//   ROW_DEPTH = DIN_TS_DIM_1 / DIN_P_DIM_1
//   ADDR_W    = max(1, $clog2(IN_DEPTH*OUT_DEPTH))
//  A non-divisible size is an elaboration $error.
// PORTS
//  clk             in   1                clock
//  rst             in   1                synchronous active-high reset
//  start           in   1                begin one pass; sampled only in IDLE
//  busy            out  1                high whenever state != IDLE
//  done            out  1                one-cycle pulse after the final tile handshake
//  rom_rd_en       out  1                ROM read strobe
//  rom_addr        out  ADDR_W           tile address = out_blk*IN_DEPTH + in_blk
//  rom_rdata       in   WP x (P0*P1)     unpacked tile; valid exactly 1 cycle after rom_rd_en
//  data_out        out  WP x (P0*P1)     unpacked tile to the linear core
//  data_out_valid  out  1                tile valid
//  data_out_ready  in   1                core accepts tile
//  data_out_last_in out 1                tile is in_blk == IN_DEPTH-1 (flush accumulator)
//  data_out_last   out  1                final tile of the pass
// BEHAVIOUR
//  Reset: all outputs go to 0, state IDLE, counters 0, FIFO empty, in-flight count 0.
//   rst mid-pass aborts the pass with no done pulse; ROM data returning after reset is dropped.
//  FSM: IDLE --start--> RUN --final address issued--> DRAIN --final tile handshake--> IDLE.
//   done is high in the first IDLE cycle.
//   start while busy is ignored and never queued.
//  Issue order, nested loops (outermost first): row 0..ROW_DEPTH-1, out_blk 0..OUT_DEPTH-1, in_blk 0..IN_DEPTH-1.
//   T = ROW_DEPTH*OUT_DEPTH*IN_DEPTH tiles per pass.
//   The address sequence 0..IN_DEPTH*OUT_DEPTH-1 repeats once per row.
//   Each counter wraps to 0 and carries into the next outer counter.
//  Buffering: 2-entry FIFO holding {tile, last_in, last}; sidebands are computed at issue time.
//   Issue a read only in RUN when fifo_count + inflight - pop < 2, where pop = valid & ready.
//   This guarantees FIFO overflow never occurs.
//   ROM data is written to the FIFO on the cycle it returns.
//   data_out, last_in and last come from the FIFO head; valid = FIFO not empty.
//  Handshake: once valid is asserted, data_out and sidebands hold steady until ready; valid never drops without a handshake.
//  Latency: start in cycle 0 -> rom_rd_en in cycle 1 -> data_out_valid in cycle 3.
//   Throughput is 1 tile/cycle while ready stays high.
//   Simultaneous FIFO push and pop is legal at any occupancy.
//  Degenerate case IN_DEPTH=OUT_DEPTH=ROW_DEPTH=1: single tile with last_in=last=1, address 0 every pass.
// TESTING
//  T1 params 8/2, 6/2, rows 2 (IN=4, OUT=3, T=24), ready=1, start@0:
//   valid cycles 3..26; addresses 0..11 twice; last_in at addr 3,7,11; last on tile 24;
//   busy high cycles 1..26; done pulse in cycle 27.
//  T2 same params, ready random 30% duty: identical tile/sideband sequence;
//   no tile dropped or duplicated; data stable while valid & !ready; FIFO never overflows.
//  T3 start re-pulsed in cycles 5 and 20: exactly 24 tiles and one done pulse;
//   start in cycle 30 (IDLE) launches a fresh pass from address 0.
//  T4 rst in cycle 10 of a pass: cycle 11 has busy=0, valid=0, no done;
//   a new start produces a full clean 24-tile pass.
//  T5 ready held low after start: at most 2 tiles buffered and rom_rd_en stops;
//   after ready rises, the sequence resumes in order with no gaps in addresses.
//  T6 degenerate 4/4, 2/2, rows 1: single tile at addr 0, last_in=last=1, done in cycle 4 with ready=1.

Source files
------------

// File: rtl/linear_weight_tile_scheduler_if.sv
// Weight-tile bus for linear_weight_tile_scheduler: ROM read port plus the
// valid/ready tile stream toward the linear core.
interface linear_weight_tile_scheduler_if #(
  parameter int WP     = 8,
  parameter int NE     = 4,
  parameter int ADDR_W = 4
);
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [WP-1:0]     rom_rdata [NE];
  logic [WP-1:0]     data_out [NE];
  logic              data_out_valid;
  logic              data_out_ready;
  logic              data_out_last_in;
  logic              data_out_last;

  modport master (
    output rom_rd_en, rom_addr, data_out, data_out_valid, data_out_last_in, data_out_last,
    input  rom_rdata, data_out_ready
  );

  modport slave (
    input  rom_rd_en, rom_addr, data_out, data_out_valid, data_out_last_in, data_out_last,
    output rom_rdata, data_out_ready
  );
endinterface

// File: rtl/linear_weight_tile_scheduler.sv
// Walks the weight ROM in fixed_linear consumption order (row, out_blk, in_blk)
// and streams each tile with flush/end-of-pass sidebands through a 2-entry FIFO.
module linear_weight_tile_scheduler #(
  parameter int WEIGHT_PRECISION_0          = 8,
  parameter int WEIGHT_TENSOR_SIZE_DIM_0    = 784,
  parameter int WEIGHT_PARALLELISM_DIM_0    = 28,
  parameter int WEIGHT_TENSOR_SIZE_DIM_1    = 10,
  parameter int WEIGHT_PARALLELISM_DIM_1    = 2,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg,
  linear_weight_tile_scheduler_if.master bus
);

  localparam int IN_DEPTH  = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0;
  localparam int OUT_DEPTH = WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_1;
  localparam int ROW_DEPTH = DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1;
  localparam int NE        = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int ADDR_W    = (IN_DEPTH * OUT_DEPTH > 1) ? $clog2(IN_DEPTH * OUT_DEPTH) : 1;
  localparam int IN_W      = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OUT_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int ROW_W     = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;

  if (WEIGHT_TENSOR_SIZE_DIM_0 % WEIGHT_PARALLELISM_DIM_0 != 0) begin : g_chk_dim0
    $error("WEIGHT_TENSOR_SIZE_DIM_0 not a multiple of WEIGHT_PARALLELISM_DIM_0");
  end
  if (WEIGHT_TENSOR_SIZE_DIM_1 % WEIGHT_PARALLELISM_DIM_1 != 0) begin : g_chk_dim1
    $error("WEIGHT_TENSOR_SIZE_DIM_1 not a multiple of WEIGHT_PARALLELISM_DIM_1");
  end
  if (DATA_IN_0_TENSOR_SIZE_DIM_1 % DATA_IN_0_PARALLELISM_DIM_1 != 0) begin : g_chk_rows
    $error("DATA_IN_0_TENSOR_SIZE_DIM_1 not a multiple of DATA_IN_0_PARALLELISM_DIM_1");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
  typedef logic [NE-1:0][WEIGHT_PRECISION_0-1:0] tile_t;

  state_t            state_q, state_d;
  logic              done_q;
  logic [IN_W-1:0]   in_blk_q;
  logic [OUT_W-1:0]  out_blk_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic              in_wrap, out_wrap, row_wrap, last_issue;
  logic              issue, pop, push, head_last;
  logic [2:0]        occupancy;

  logic              inflight_q, side_last_in_q, side_last_q;
  tile_t             rdata_packed;
  tile_t             fifo_tile [2];
  logic              fifo_last_in [2];
  logic              fifo_last [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fifo_count_q;

  // Stream handshake: a tile transfers on any cycle with data_out_valid & data_out_ready.
  // valid is raised only when the FIFO holds a tile and drops only after a transfer;
  // the head entry (data and both sidebands) cannot change while it waits.
  assign pop       = bus.data_out_valid & bus.data_out_ready;
  assign push      = inflight_q;
  assign head_last = fifo_last[rd_ptr_q];

  assign in_wrap    = (in_blk_q == IN_W'(IN_DEPTH - 1));
  assign out_wrap   = (out_blk_q == OUT_W'(OUT_DEPTH - 1));
  assign row_wrap   = (row_q == ROW_W'(ROW_DEPTH - 1));
  assign last_issue = in_wrap & out_wrap & row_wrap;

  // Reads already in flight count as occupied slots so a returning tile always fits.
  assign occupancy = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == S_RUN) && (occupancy < 3'd2);

  always_comb begin
    for (int e = 0; e < NE; e++) rdata_packed[e] = bus.rom_rdata[e];
  end

  always_comb begin
    for (int e = 0; e < NE; e++) bus.data_out[e] = fifo_tile[rd_ptr_q][e];
  end

  assign bus.data_out_valid   = (fifo_count_q != 2'd0);
  assign bus.data_out_last_in = fifo_last_in[rd_ptr_q];
  assign bus.data_out_last    = fifo_last[rd_ptr_q];
  assign bus.rom_rd_en        = issue;
  assign bus.rom_addr         = addr_q;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DRAIN) && pop && head_last;
    end
  end

  // Tile counters carry in_blk -> out_blk -> row; the ROM address restarts every row.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_blk_q  <= '0;
      out_blk_q <= '0;
      row_q     <= '0;
      addr_q    <= '0;
    end else if (issue) begin
      if (in_wrap) begin
        in_blk_q <= '0;
        if (out_wrap) begin
          out_blk_q <= '0;
          row_q     <= row_wrap ? '0 : row_q + ROW_W'(1);
        end else begin
          out_blk_q <= out_blk_q + OUT_W'(1);
        end
      end else begin
        in_blk_q <= in_blk_q + IN_W'(1);
      end
      addr_q <= (in_wrap && out_wrap) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      side_last_in_q <= 1'b0;
      side_last_q    <= 1'b0;
    end else begin
      inflight_q     <= issue;
      side_last_in_q <= in_wrap;
      side_last_q    <= last_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_tile[i]    <= '0;
        fifo_last_in[i] <= 1'b0;
        fifo_last[i]    <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_tile[wr_ptr_q]    <= rdata_packed;
        fifo_last_in[wr_ptr_q] <= side_last_in_q;
        fifo_last[wr_ptr_q]    <= side_last_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_weight_tile_scheduler.sv
// Bench for linear_weight_tile_scheduler: main instance (IN=4, OUT=3, rows=2)
// and a degenerate single-tile instance, both fed by behavioural ROMs.
module tb_linear_weight_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       busy, done, busy2, done2;
  logic [1:0] state_dbg, state_dbg2;

  int vectors = 0;
  int errors = 0;
  int pop_count = 0;
  int done_count = 0;
  int rd_count = 0;

  // Expected tile entry: {last_in, last, addr[3:0]}
  logic [5:0] exp_q[$];
  logic [3:0] addr_q[$];

  linear_weight_tile_scheduler_if #(.WP(8), .NE(4), .ADDR_W(4)) bus ();
  linear_weight_tile_scheduler_if #(.WP(8), .NE(8), .ADDR_W(1)) bus2 ();

  linear_weight_tile_scheduler #(
    .WEIGHT_PRECISION_0(8), .WEIGHT_TENSOR_SIZE_DIM_0(8), .WEIGHT_PARALLELISM_DIM_0(2),
    .WEIGHT_TENSOR_SIZE_DIM_1(6), .WEIGHT_PARALLELISM_DIM_1(2),
    .DATA_IN_0_TENSOR_SIZE_DIM_1(2), .DATA_IN_0_PARALLELISM_DIM_1(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .state_dbg(state_dbg), .bus(bus)
  );

  linear_weight_tile_scheduler #(
    .WEIGHT_PRECISION_0(8), .WEIGHT_TENSOR_SIZE_DIM_0(4), .WEIGHT_PARALLELISM_DIM_0(4),
    .WEIGHT_TENSOR_SIZE_DIM_1(2), .WEIGHT_PARALLELISM_DIM_1(2),
    .DATA_IN_0_TENSOR_SIZE_DIM_1(1), .DATA_IN_0_PARALLELISM_DIM_1(1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .state_dbg(state_dbg2), .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input int addr, input int e);
    return 8'(addr * 37 + e * 11 + 5);
  endfunction

  function automatic logic [31:0] exp_tile(input int addr);
    logic [31:0] t;
    for (int e = 0; e < 4; e++) t[e*8 +: 8] = rom_word(addr, e);
    return t;
  endfunction

  // ROMs: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    for (int e = 0; e < 4; e++)
      bus.rom_rdata[e] <= bus.rom_rd_en ? rom_word(int'(bus.rom_addr), e) : 8'($urandom);
    for (int e = 0; e < 8; e++)
      bus2.rom_rdata[e] <= bus2.rom_rd_en ? rom_word(int'(bus2.rom_addr), e) : 8'($urandom);
  end

  task automatic push_pass();
    for (int row = 0; row < 2; row++)
      for (int a = 0; a < 12; a++) begin
        addr_q.push_back(4'(a));
        exp_q.push_back({(a % 4 == 3), (row == 1 && a == 11), 4'(a)});
      end
  endtask

  task automatic monitor();
    logic        prev_hold = 1'b0;
    logic [33:0] prev_bus = '0;
    logic [33:0] cur_bus;
    logic [31:0] got;
    logic [5:0]  ent;
    logic [3:0]  a;
    forever begin
      @(negedge clk);
      for (int e = 0; e < 4; e++) got[e*8 +: 8] = bus.data_out[e];
      cur_bus = {bus.data_out_last_in, bus.data_out_last, got};
      if (bus.rom_rd_en) begin
        rd_count++;
        vectors++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rom_addr unexpected read got=%0d want=none", bus.rom_addr);
        end else begin
          a = addr_q.pop_front();
          if (bus.rom_addr !== a) begin
            errors++;
            $display("FAIL rom_addr got=%0d want=%0d", bus.rom_addr, a);
          end
        end
      end
      if (prev_hold && !rst) begin
        vectors++;
        if (bus.data_out_valid !== 1'b1 || cur_bus !== prev_bus) begin
          errors++;
          $display("FAIL hold_stable got=%b/%h want=1/%h", bus.data_out_valid, cur_bus, prev_bus);
        end
      end
      if (bus.data_out_valid && bus.data_out_ready) begin
        pop_count++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tile_extra got=%h want=none", got);
        end else begin
          ent = exp_q.pop_front();
          if (got !== exp_tile(int'(ent[3:0]))) begin
            errors++;
            $display("FAIL tile_data got=%h want=%h (addr %0d)", got, exp_tile(int'(ent[3:0])), ent[3:0]);
          end
          vectors++;
          if ({bus.data_out_last_in, bus.data_out_last} !== ent[5:4]) begin
            errors++;
            $display("FAIL sidebands got=%b want=%b (addr %0d)",
                     {bus.data_out_last_in, bus.data_out_last}, ent[5:4], ent[3:0]);
          end
        end
      end
      if (done) done_count++;
      prev_hold = bus.data_out_valid && !bus.data_out_ready && !rst;
      prev_bus  = cur_bus;
    end
  endtask

  task automatic wait_pass_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk) #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_out_ready  = 1'b1;
    bus2.data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, bus.data_out_valid, bus.rom_rd_en, bus.data_out_last_in, bus.data_out_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000",
               {busy, done, bus.data_out_valid, bus.rom_rd_en, bus.data_out_last_in, bus.data_out_last});
    end
    vectors++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d want=0", state_dbg);
    end
    vectors++;
    if ({bus.data_out[3], bus.data_out[2], bus.data_out[1], bus.data_out[0]} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0",
               {bus.data_out[3], bus.data_out[2], bus.data_out[1], bus.data_out[0]});
    end
    vectors++;
    if ({busy2, done2, bus2.data_out_valid, bus2.rom_rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs2 got=%b want=0000", {busy2, done2, bus2.data_out_valid, bus2.rom_rd_en});
    end
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_single_pass();
    bus.data_out_ready = 1'b1;
    push_pass();
    start = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== (c >= 1 && c <= 26)) begin
        errors++;
        $display("FAIL t1_busy cycle %0d got=%b want=%b", c, busy, (c >= 1 && c <= 26));
      end
      vectors++;
      if (bus.data_out_valid !== (c >= 3 && c <= 26)) begin
        errors++;
        $display("FAIL t1_valid cycle %0d got=%b want=%b", c, bus.data_out_valid, (c >= 3 && c <= 26));
      end
      vectors++;
      if (done !== (c == 27)) begin
        errors++;
        $display("FAIL t1_done cycle %0d got=%b want=%b", c, done, (c == 27));
      end
      vectors++;
      if (bus.rom_rd_en !== (c >= 1 && c <= 24)) begin
        errors++;
        $display("FAIL t1_rd_en cycle %0d got=%b want=%b", c, bus.rom_rd_en, (c >= 1 && c <= 24));
      end
      @(posedge clk) #1;
      start = 1'b0;
    end
    vectors++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL t1_drained got=%0d/%0d want=0/0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    int pops0;
    pops0 = pop_count;
    ok = 1'b0;
    push_pass();
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk) #1;
      start = 1'b0;
      bus.data_out_ready = ($urandom_range(0, 9) < 3);
    end
    @(posedge clk) #1;
    start = 1'b0;
    bus.data_out_ready = 1'b1;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL t2_timeout got=no_done want=done");
    end
    vectors++;
    if (pop_count - pops0 != 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t2_tile_count got=%0d left=%0d want=24 left=0", pop_count - pops0, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int pops0, dones0;
    pops0 = pop_count;
    dones0 = done_count;
    bus.data_out_ready = 1'b1;
    push_pass();
    for (int c = 0; c < 30; c++) begin
      start = (c == 0 || c == 5 || c == 20);
      @(negedge clk);
      @(posedge clk) #1;
    end
    start = 1'b0;
    vectors++;
    if (pop_count - pops0 != 24 || done_count - dones0 != 1) begin
      errors++;
      $display("FAIL t3_one_pass got=%0d tiles %0d dones want=24 tiles 1 done",
               pop_count - pops0, done_count - dones0);
    end
    vectors++;
    if (busy !== 1'b0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL t3_idle got=busy %b pending %0d want=0 0", busy, addr_q.size());
    end
    push_pass();
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    wait_pass_end(60, ok);
    vectors++;
    if (!ok || exp_q.size() != 0 || pop_count - pops0 != 48) begin
      errors++;
      $display("FAIL t3_fresh_pass got=ok %b tiles %0d want=ok 1 tiles 48", ok, pop_count - pops0);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    int pops0, dones0;
    bus.data_out_ready = 1'b1;
    push_pass();
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      rst = (c == 10);
      @(negedge clk);
      @(posedge clk) #1;
    end
    start = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    dones0 = done_count;
    @(negedge clk);
    vectors++;
    if ({busy, bus.data_out_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL t4_after_rst got=%b want=000", {busy, bus.data_out_valid, done});
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (done_count != dones0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_no_done got=%0d dones busy %b want=0 dones busy 0", done_count - dones0, busy);
    end
    pops0 = pop_count;
    push_pass();
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    wait_pass_end(60, ok);
    vectors++;
    if (!ok || exp_q.size() != 0 || pop_count - pops0 != 24) begin
      errors++;
      $display("FAIL t4_clean_pass got=ok %b tiles %0d want=ok 1 tiles 24", ok, pop_count - pops0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int rd0, pops0;
    rd0 = rd_count;
    pops0 = pop_count;
    bus.data_out_ready = 1'b0;
    push_pass();
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rd_count - rd0 != 2 || bus.rom_rd_en !== 1'b0 || bus.data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL t5_stall got=%0d reads rd_en %b valid %b want=2 reads rd_en 0 valid 1",
               rd_count - rd0, bus.rom_rd_en, bus.data_out_valid);
    end
    @(posedge clk) #1;
    bus.data_out_ready = 1'b1;
    wait_pass_end(60, ok);
    vectors++;
    if (!ok || exp_q.size() != 0 || addr_q.size() != 0 || pop_count - pops0 != 24) begin
      errors++;
      $display("FAIL t5_resume got=ok %b tiles %0d want=ok 1 tiles 24", ok, pop_count - pops0);
    end
  endtask

  task automatic test_degenerate();
    logic [63:0] got, want;
    for (int e = 0; e < 8; e++) want[e*8 +: 8] = rom_word(0, e);
    for (int p = 0; p < 2; p++) begin
      start2 = 1'b1;
      for (int c = 0; c <= 6; c++) begin
        @(negedge clk);
        for (int e = 0; e < 8; e++) got[e*8 +: 8] = bus2.data_out[e];
        vectors++;
        if ({busy2, bus2.data_out_valid, done2, bus2.rom_rd_en} !==
            {(c >= 1 && c <= 3), (c == 3), (c == 4), (c == 1)}) begin
          errors++;
          $display("FAIL t6_ctrl pass %0d cycle %0d got=%b want=%b", p, c,
                   {busy2, bus2.data_out_valid, done2, bus2.rom_rd_en},
                   {(c >= 1 && c <= 3), (c == 3), (c == 4), (c == 1)});
        end
        if (c == 1) begin
          vectors++;
          if (bus2.rom_addr !== 1'b0) begin
            errors++;
            $display("FAIL t6_addr got=%0d want=0", bus2.rom_addr);
          end
        end
        if (c == 3) begin
          vectors++;
          if (got !== want || {bus2.data_out_last_in, bus2.data_out_last} !== 2'b11) begin
            errors++;
            $display("FAIL t6_tile got=%h/%b want=%h/11", got,
                     {bus2.data_out_last_in, bus2.data_out_last}, want);
          end
        end
        @(posedge clk) #1;
        start2 = 1'b0;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_pass();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_pass();
    test_backpressure();
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
